// File: rtl/lzw_code_uart_tx.sv
// lzw_code_uart_tx: sends 12-bit LZW codes as three lowercase ASCII hex
// characters (MS nibble first) over an 8N1 UART line, then an EOF character
// once the compressor reports completion.
module lzw_code_uart_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] EOF_CODE     = 8'h0D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] code_in,
    input  logic        code_valid,
    output logic        code_ready,
    input  logic        lzw_done,
    output logic        tx,
    output logic        tx_busy,
    output logic        final_done
);
    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    shreg;
    logic [11:0]   code_q;
    logic [1:0]    nib_idx;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          eof_q;
    logic          done_pend;
    logic          lzw_done_q;

    logic          baud_end;
    logic          lzw_rise;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign lzw_rise = lzw_done & ~lzw_done_q;

    // Nibble to lowercase ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h61 + ({4'h0, n} - 8'd10);
    endfunction

    // Transmit FSM: all outputs registered so tx never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            code_q     <= '0;
            nib_idx    <= '0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            eof_q      <= 1'b0;
            done_pend  <= 1'b0;
            lzw_done_q <= 1'b0;
            tx         <= 1'b1;
            code_ready <= 1'b1;
            tx_busy    <= 1'b0;
            final_done <= 1'b0;
        end else begin
            lzw_done_q <= lzw_done;
            final_done <= 1'b0;
            // A repeat edge while EOF is already owed changes nothing.
            if (lzw_rise) done_pend <= 1'b1;

            if (state != IDLE) baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    // A waiting code goes before the EOF so EOF is always last.
                    if (code_valid) begin
                        code_q     <= code_in;
                        nib_idx    <= 2'd2;
                        shreg      <= hex_char(code_in[11:8]);
                        state      <= START;
                        tx         <= 1'b0;
                        code_ready <= 1'b0;
                        tx_busy    <= 1'b1;
                    end else if (done_pend) begin
                        shreg      <= EOF_CODE;
                        eof_q      <= 1'b1;
                        state      <= START;
                        tx         <= 1'b0;
                        code_ready <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        if (eof_q) begin
                            final_done <= 1'b1;
                            eof_q      <= 1'b0;
                            done_pend  <= 1'b0;
                            state      <= IDLE;
                            code_ready <= 1'b1;
                            tx_busy    <= 1'b0;
                        end else if (nib_idx != 2'd0) begin
                            // Next nibble goes out back-to-back, no idle gap.
                            nib_idx <= nib_idx - 1'b1;
                            shreg   <= hex_char((nib_idx == 2'd2) ? code_q[7:4] : code_q[3:0]);
                            state   <= START;
                            tx      <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            code_ready <= 1'b1;
                            tx_busy    <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lzw_code_uart_tx.sv
// Bench for lzw_code_uart_tx: directed steps, a UART line monitor and a
// queue of expected characters.
module tb_lzw_code_uart_tx;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] code_in = '0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic        lzw_done = 1'b0;
    logic        tx;
    logic        tx_busy;
    logic        final_done;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          fd_cnt  = 0;
    logic [7:0]  sb[$];

    lzw_code_uart_tx #(.CLKS_PER_BIT(CPB), .EOF_CODE(8'h0D)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .lzw_done(lzw_done), .tx(tx),
        .tx_busy(tx_busy), .final_done(final_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (final_done === 1'b1) fd_cnt <= fd_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string digits;
        digits = "0123456789abcdef";
        return digits[n];
    endfunction

    task automatic push_code(input logic [11:0] c);
        sb.push_back(hexc(c[11:8]));
        sb.push_back(hexc(c[7:4]));
        sb.push_back(hexc(c[3:0]));
    endtask

    // UART receiver: samples each bit mid-period, drops frames hit by reset.
    initial begin
        logic [7:0] ch;
        logic       stop_b;
        logic       aborted;
        logic [7:0] exp_ch;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                aborted = 1'b0;
                ch      = '0;
                stop_b  = 1'b0;
                for (int c = 1; c <= 9*CPB + 2; c++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                    for (int i = 0; i < 8; i++)
                        if (c == (1 + i)*CPB + 2) ch[i] = tx;
                    if (c == 9*CPB + 2) stop_b = tx;
                end
                if (!aborted) begin
                    if (sb.size() == 0) begin
                        check("unexpected_char", {24'h0, ch}, 32'hffff_ffff);
                    end else begin
                        exp_ch = sb.pop_front();
                        check("rx_char", {24'h0, ch}, {24'h0, exp_ch});
                        check("rx_stop", {31'h0, stop_b}, 32'h1);
                    end
                end
            end
        end
    end

    // Present one code for a single acceptance; returns the acceptance cycle.
    task automatic send(input logic [11:0] c, output int t_acc);
        @(negedge clk);
        code_in    = c;
        code_valid = 1'b1;
        push_code(c);
        t_acc = cyc + 1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    initial begin
        int t1, t2, n, hi, tf, fd_base;
        logic busy_at_fd;

        // 1: reset and idle line
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_code_ready", {31'h0, code_ready}, 32'h1);
        check("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
        check("rst_final_done", {31'h0, final_done}, 32'h0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || final_done !== 1'b0) n++;
        end
        check("idle_activity", n, 0);

        // 2: 0x1E3, ready low for 30 bit times
        send(12'h1E3, t1);
        n = 0;
        while (code_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("ready_low_cycles", n, 30*CPB);
        check("busy_after_code", {31'h0, tx_busy}, 32'h0);
        repeat (5) @(negedge clk);
        check("sb_empty_1e3", sb.size(), 0);

        // 3: 0xA0F, hex map boundaries
        send(12'hA0F, t1);
        repeat (30*CPB + 10) @(negedge clk);
        check("sb_empty_a0f", sb.size(), 0);

        // 4: back-to-back codes with valid held high
        @(negedge clk);
        code_in    = 12'h063;
        code_valid = 1'b1;
        push_code(12'h063);
        push_code(12'h031);
        t1 = cyc + 1;
        @(negedge clk);
        code_in = 12'h031;
        hi = 0;
        t2 = 0;
        for (int k = 0; k < 400; k++) begin
            if (code_ready === 1'b1) begin
                hi++;
                t2 = cyc + 1;
            end else if (hi != 0) begin
                break;
            end
            @(negedge clk);
        end
        code_valid = 1'b0;
        check("second_accept_gap", t2 - t1, 30*CPB + 1);
        check("ready_high_between", hi, 1);
        repeat (30*CPB + 10) @(negedge clk);
        check("sb_empty_063031", sb.size(), 0);

        // 5: lzw_done with the last code, EOF follows
        fd_base = fd_cnt;
        @(negedge clk);
        code_in    = 12'h100;
        code_valid = 1'b1;
        lzw_done   = 1'b1;
        push_code(12'h100);
        sb.push_back(8'h0D);
        t1 = cyc + 1;
        @(negedge clk);
        code_valid = 1'b0;
        tf = 0;
        busy_at_fd = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (final_done === 1'b1) begin
                tf = cyc;
                busy_at_fd = tx_busy;
            end
        end
        check("final_done_count", fd_cnt - fd_base, 1);
        check("final_done_time", tf - t1, 40*CPB + 1);
        check("busy_at_final_done", {31'h0, busy_at_fd}, 32'h0);
        check("sb_empty_eof", sb.size(), 0);
        lzw_done = 1'b0;
        repeat (5) @(negedge clk);

        // 6: reset during data bit 3, then clean retransmit
        fd_base = fd_cnt;
        send(12'h1E3, t1);
        n = 0;
        while (cyc < t1 + 4*CPB + 1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_tx", {31'h0, tx}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", {31'h0, code_ready}, 32'h1);
        check("mid_rst_busy", {31'h0, tx_busy}, 32'h0);
        repeat (60) @(negedge clk);
        check("mid_rst_no_final", fd_cnt - fd_base, 0);
        sb.delete();
        send(12'h0FF, t1);
        repeat (30*CPB + 10) @(negedge clk);
        check("sb_empty_0ff", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
